// File: rtl/rs_alu_pkg.sv
// Shared widths, entry/operand types and the operand wakeup helper for the ALU reservation station.
package rs_alu_pkg;

  localparam int RV32_DATA_WIDTH = 32;
  localparam int RRF_ENT_SEL     = 6;
  localparam int RS_ENT_NUM      = 8;
  localparam int RS_ENT_SEL      = 3;
  localparam int OP_WIDTH        = 16;

  typedef struct packed {
    logic                       fin;
    logic [RRF_ENT_SEL-1:0]     tag;
    logic [RV32_DATA_WIDTH-1:0] res;
  } fin_bus_t;

  typedef struct packed {
    logic [RV32_DATA_WIDTH-1:0] val;
    logic                       vld;
  } operand_t;

  typedef struct packed {
    logic                   busy;
    logic [OP_WIDTH-1:0]    op;
    logic [RRF_ENT_SEL-1:0] rrftag;
    operand_t               src1;
    operand_t               src2;
  } rs_ent_t;

  // A pending operand keeps its tag in the low bits of val; ALU beats MUL beats LD.
  function automatic operand_t wake(input operand_t opnd, input fin_bus_t alu,
                                    input fin_bus_t mul, input fin_bus_t ld);
    operand_t r;
    r = opnd;
    if (!opnd.vld) begin
      if (alu.fin && alu.tag == opnd.val[RRF_ENT_SEL-1:0])
        r = '{val: alu.res, vld: 1'b1};
      else if (mul.fin && mul.tag == opnd.val[RRF_ENT_SEL-1:0])
        r = '{val: mul.res, vld: 1'b1};
      else if (ld.fin && ld.tag == opnd.val[RRF_ENT_SEL-1:0])
        r = '{val: ld.res, vld: 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_alu_if.sv
// Dispatch, finish-bus, issue and status signals of the ALU reservation station.
interface rs_alu_if;
  import rs_alu_pkg::*;

  logic                       i_flush;
  logic                       i_dp_vld;
  logic [OP_WIDTH-1:0]        i_dp_op;
  logic [RRF_ENT_SEL-1:0]     i_dp_rrftag;
  logic [RV32_DATA_WIDTH-1:0] i_dp_src1;
  logic [RV32_DATA_WIDTH-1:0] i_dp_src2;
  logic                       i_dp_src1_vld;
  logic                       i_dp_src2_vld;
  logic [RRF_ENT_SEL-1:0]     i_ex_alu_rrftag;
  logic                       i_exfin_alu;
  logic [RV32_DATA_WIDTH-1:0] i_exfin_alu_res;
  logic [RRF_ENT_SEL-1:0]     i_ex_mul_rrftag;
  logic                       i_exfin_mul;
  logic [RV32_DATA_WIDTH-1:0] i_exfin_mul_res;
  logic [RRF_ENT_SEL-1:0]     i_ex_ld_rrftag;
  logic                       i_exfin_ld;
  logic [RV32_DATA_WIDTH-1:0] i_exfin_ld_res;
  logic                       i_issue_rdy;
  logic                       o_issue_vld;
  logic [OP_WIDTH-1:0]        o_issue_op;
  logic [RRF_ENT_SEL-1:0]     o_issue_rrftag;
  logic [RV32_DATA_WIDTH-1:0] o_issue_src1;
  logic [RV32_DATA_WIDTH-1:0] o_issue_src2;
  logic                       o_full;
  logic                       o_empty;
  logic [RS_ENT_SEL:0]        o_cnt;

  modport master (
    output i_flush, i_dp_vld, i_dp_op, i_dp_rrftag, i_dp_src1, i_dp_src2,
           i_dp_src1_vld, i_dp_src2_vld,
           i_ex_alu_rrftag, i_exfin_alu, i_exfin_alu_res,
           i_ex_mul_rrftag, i_exfin_mul, i_exfin_mul_res,
           i_ex_ld_rrftag, i_exfin_ld, i_exfin_ld_res, i_issue_rdy,
    input  o_issue_vld, o_issue_op, o_issue_rrftag, o_issue_src1, o_issue_src2,
           o_full, o_empty, o_cnt
  );

  modport slave (
    input  i_flush, i_dp_vld, i_dp_op, i_dp_rrftag, i_dp_src1, i_dp_src2,
           i_dp_src1_vld, i_dp_src2_vld,
           i_ex_alu_rrftag, i_exfin_alu, i_exfin_alu_res,
           i_ex_mul_rrftag, i_exfin_mul, i_exfin_mul_res,
           i_ex_ld_rrftag, i_exfin_ld, i_exfin_ld_res, i_issue_rdy,
    output o_issue_vld, o_issue_op, o_issue_rrftag, o_issue_src1, o_issue_src2,
           o_full, o_empty, o_cnt
  );

endinterface

// File: rtl/rs_prio_sel.sv
// Combinational lowest-index picker: one-hot grant, encoded index and any-valid flag.
module rs_prio_sel
  import rs_alu_pkg::*;
(
  input  logic [RS_ENT_NUM-1:0] req,
  output logic [RS_ENT_NUM-1:0] grant,
  output logic [RS_ENT_SEL-1:0] idx,
  output logic                  vld
);

  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    for (int i = RS_ENT_NUM - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = RS_ENT_SEL'(i);
        vld = 1'b1;
      end
    end
    grant[idx] = vld;
  end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: tag wakeup from three finish buses, one dispatch and one issue per cycle.
// Define RS_AGE_SEL_EN for oldest-first issue; otherwise the lowest-index ready entry issues.
module rs_alu
  import rs_alu_pkg::*;
(
  input logic     i_clk,
  input logic     i_rst,
  rs_alu_if.slave bus
);

  rs_ent_t               ents [RS_ENT_NUM];
  logic [RS_ENT_NUM-1:0] busy_vec;
  logic [RS_ENT_NUM-1:0] ready_vec;
  logic [RS_ENT_NUM-1:0] free_grant;
  logic [RS_ENT_NUM-1:0] issue_grant;
  logic [RS_ENT_SEL-1:0] free_idx;
  logic [RS_ENT_SEL-1:0] issue_idx;
  logic                  free_vld;
  logic                  issue_vld;
  logic                  dp_fire;
  logic                  issue_fire;
  logic [RS_ENT_SEL:0]   cnt;
  fin_bus_t              alu_fin;
  fin_bus_t              mul_fin;
  fin_bus_t              ld_fin;
  rs_ent_t               dp_ent;
  rs_ent_t               sel_ent;

  assign alu_fin = '{fin: bus.i_exfin_alu, tag: bus.i_ex_alu_rrftag, res: bus.i_exfin_alu_res};
  assign mul_fin = '{fin: bus.i_exfin_mul, tag: bus.i_ex_mul_rrftag, res: bus.i_exfin_mul_res};
  assign ld_fin  = '{fin: bus.i_exfin_ld,  tag: bus.i_ex_ld_rrftag,  res: bus.i_exfin_ld_res};

  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    cnt       = '0;
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      busy_vec[i]  = ents[i].busy;
      ready_vec[i] = ents[i].busy && ents[i].src1.vld && ents[i].src2.vld;
      cnt          = cnt + {{RS_ENT_SEL{1'b0}}, ents[i].busy};
    end
  end

  rs_prio_sel u_free_sel (
    .req   (~busy_vec),
    .grant (free_grant),
    .idx   (free_idx),
    .vld   (free_vld)
  );

`ifdef RS_AGE_SEL_EN
  logic [RS_ENT_SEL-1:0] age [RS_ENT_NUM];

  always_comb begin
    logic [RS_ENT_SEL-1:0] best_age;
    issue_vld   = 1'b0;
    issue_idx   = '0;
    issue_grant = '0;
    best_age    = '0;
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      if (ready_vec[i] && (!issue_vld || age[i] < best_age)) begin
        issue_vld = 1'b1;
        issue_idx = RS_ENT_SEL'(i);
        best_age  = age[i];
      end
    end
    issue_grant[issue_idx] = issue_vld;
  end

  // Ages stay dense: a new entry is youngest, and entries behind an issued one move up.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RS_ENT_NUM; i++) age[i] <= '0;
    end else if (!bus.i_flush) begin
      if (issue_fire) begin
        for (int i = 0; i < RS_ENT_NUM; i++)
          if (ents[i].busy && age[i] > age[issue_idx]) age[i] <= age[i] - RS_ENT_SEL'(1);
      end
      if (dp_fire)
        age[free_idx] <= issue_fire ? cnt[RS_ENT_SEL-1:0] - RS_ENT_SEL'(1) : cnt[RS_ENT_SEL-1:0];
    end
  end
`else
  rs_prio_sel u_ready_sel (
    .req   (ready_vec),
    .grant (issue_grant),
    .idx   (issue_idx),
    .vld   (issue_vld)
  );
`endif

  assign dp_fire    = bus.i_dp_vld && free_vld;
  assign issue_fire = issue_vld && bus.i_issue_rdy;

  always_comb begin
    dp_ent        = '0;
    dp_ent.busy   = 1'b1;
    dp_ent.op     = bus.i_dp_op;
    dp_ent.rrftag = bus.i_dp_rrftag;
    dp_ent.src1   = wake('{val: bus.i_dp_src1, vld: bus.i_dp_src1_vld}, alu_fin, mul_fin, ld_fin);
    dp_ent.src2   = wake('{val: bus.i_dp_src2, vld: bus.i_dp_src2_vld}, alu_fin, mul_fin, ld_fin);
  end

  // The free slot comes from pre-edge busy bits, so it never collides with the issuing entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RS_ENT_NUM; i++) ents[i] <= '0;
    end else if (bus.i_flush) begin
      for (int i = 0; i < RS_ENT_NUM; i++) ents[i].busy <= 1'b0;
    end else begin
      for (int i = 0; i < RS_ENT_NUM; i++) begin
        if (ents[i].busy) begin
          ents[i].src1 <= wake(ents[i].src1, alu_fin, mul_fin, ld_fin);
          ents[i].src2 <= wake(ents[i].src2, alu_fin, mul_fin, ld_fin);
          if (issue_fire && issue_grant[i]) ents[i].busy <= 1'b0;
        end
      end
      if (dp_fire) ents[free_idx] <= dp_ent;
    end
  end

  always_comb begin
    sel_ent = ents[issue_idx];
    bus.o_issue_vld    = issue_vld;
    bus.o_issue_op     = issue_vld ? sel_ent.op       : '0;
    bus.o_issue_rrftag = issue_vld ? sel_ent.rrftag   : '0;
    bus.o_issue_src1   = issue_vld ? sel_ent.src1.val : '0;
    bus.o_issue_src2   = issue_vld ? sel_ent.src2.val : '0;
  end

  assign bus.o_full  = ~|free_grant;
  assign bus.o_empty = ~|busy_vec;
  assign bus.o_cnt   = cnt;

endmodule

// File: tb/tb_rs_alu.sv
// Directed self-checking bench for rs_alu: reset, dispatch, wakeup, capture, full/backpressure, flush.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  rs_alu_if bus ();

  rs_alu dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_flush         = 1'b0;
    bus.i_dp_vld        = 1'b0;
    bus.i_dp_op         = '0;
    bus.i_dp_rrftag     = '0;
    bus.i_dp_src1       = '0;
    bus.i_dp_src2       = '0;
    bus.i_dp_src1_vld   = 1'b0;
    bus.i_dp_src2_vld   = 1'b0;
    bus.i_ex_alu_rrftag = '0;
    bus.i_exfin_alu     = 1'b0;
    bus.i_exfin_alu_res = '0;
    bus.i_ex_mul_rrftag = '0;
    bus.i_exfin_mul     = 1'b0;
    bus.i_exfin_mul_res = '0;
    bus.i_ex_ld_rrftag  = '0;
    bus.i_exfin_ld      = 1'b0;
    bus.i_exfin_ld_res  = '0;
  endtask

  task automatic applyStimulus(input logic [OP_WIDTH-1:0] op, input logic [RRF_ENT_SEL-1:0] tag,
                               input logic [31:0] s1, input logic s1v,
                               input logic [31:0] s2, input logic s2v);
    bus.i_dp_vld      = 1'b1;
    bus.i_dp_op       = op;
    bus.i_dp_rrftag   = tag;
    bus.i_dp_src1     = s1;
    bus.i_dp_src1_vld = s1v;
    bus.i_dp_src2     = s2;
    bus.i_dp_src2_vld = s2v;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  initial begin
    idle();
    bus.i_issue_rdy = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_empty", 32'(bus.o_empty), 32'h1);
    checkOutput("rst_full", 32'(bus.o_full), 32'h0);
    checkOutput("rst_cnt", 32'(bus.o_cnt), 32'h0);
    checkOutput("rst_issue_vld", 32'(bus.o_issue_vld), 32'h0);
    checkOutput("rst_issue_src1", bus.o_issue_src1, 32'h0);

    $display("[TB] operand-complete dispatch");
    bus.i_issue_rdy = 1'b1;
    applyStimulus(16'hA5A5, 6'd5, 32'h11, 1'b1, 32'h22, 1'b1);
    checkOutput("rdy_no_bypass", 32'(bus.o_issue_vld), 32'h0);
    tick();
    idle();
    checkOutput("rdy_issue_vld", 32'(bus.o_issue_vld), 32'h1);
    checkOutput("rdy_src1", bus.o_issue_src1, 32'h11);
    checkOutput("rdy_src2", bus.o_issue_src2, 32'h22);
    checkOutput("rdy_rrftag", 32'(bus.o_issue_rrftag), 32'd5);
    checkOutput("rdy_op", 32'(bus.o_issue_op), 32'hA5A5);
    checkOutput("rdy_cnt", 32'(bus.o_cnt), 32'd1);
    tick();
    checkOutput("rdy_drained", 32'(bus.o_empty), 32'h1);
    checkOutput("rdy_drained_vld", 32'(bus.o_issue_vld), 32'h0);

    $display("[TB] wakeup from MUL");
    applyStimulus(16'h0001, 6'd9, 32'h7, 1'b0, 32'h3, 1'b1);
    tick();
    idle();
    bus.i_exfin_mul     = 1'b1;
    bus.i_ex_mul_rrftag = 6'd7;
    bus.i_exfin_mul_res = 32'hDEADBEEF;
    checkOutput("wake_pending", 32'(bus.o_issue_vld), 32'h0);
    tick();
    idle();
    checkOutput("wake_issue_vld", 32'(bus.o_issue_vld), 32'h1);
    checkOutput("wake_src1", bus.o_issue_src1, 32'hDEADBEEF);
    checkOutput("wake_src2", bus.o_issue_src2, 32'h3);
    checkOutput("wake_rrftag", 32'(bus.o_issue_rrftag), 32'd9);
    tick();
    checkOutput("wake_drained", 32'(bus.o_empty), 32'h1);

    $display("[TB] dispatch-cycle capture");
    applyStimulus(16'h0002, 6'd12, 32'h3, 1'b1, 32'h3, 1'b0);
    bus.i_exfin_alu     = 1'b1;
    bus.i_ex_alu_rrftag = 6'd3;
    bus.i_exfin_alu_res = 32'h5;
    tick();
    idle();
    checkOutput("cap_issue_vld", 32'(bus.o_issue_vld), 32'h1);
    checkOutput("cap_src1_kept", bus.o_issue_src1, 32'h3);
    checkOutput("cap_src2", bus.o_issue_src2, 32'h5);
    tick();
    applyStimulus(16'h0003, 6'd13, 32'h8, 1'b1, 32'h3, 1'b0);
    bus.i_exfin_alu     = 1'b1;
    bus.i_ex_alu_rrftag = 6'd3;
    bus.i_exfin_alu_res = 32'h1234;
    bus.i_exfin_ld      = 1'b1;
    bus.i_ex_ld_rrftag  = 6'd3;
    bus.i_exfin_ld_res  = 32'h99;
    tick();
    idle();
    checkOutput("cap_alu_over_ld", bus.o_issue_src2, 32'h1234);
    tick();

    $display("[TB] wakeup priority on a waiting entry");
    applyStimulus(16'h0004, 6'd14, 32'h21, 1'b0, 32'h22, 1'b0);
    tick();
    idle();
    bus.i_exfin_alu     = 1'b1;
    bus.i_ex_alu_rrftag = 6'h21;
    bus.i_exfin_alu_res = 32'hAAAA;
    bus.i_exfin_mul     = 1'b1;
    bus.i_ex_mul_rrftag = 6'h21;
    bus.i_exfin_mul_res = 32'hBBBB;
    bus.i_exfin_ld      = 1'b1;
    bus.i_ex_ld_rrftag  = 6'h22;
    bus.i_exfin_ld_res  = 32'hCCCC;
    tick();
    idle();
    checkOutput("prio_alu_over_mul", bus.o_issue_src1, 32'hAAAA);
    checkOutput("prio_ld_src2", bus.o_issue_src2, 32'hCCCC);
    tick();
    checkOutput("prio_drained", 32'(bus.o_empty), 32'h1);

    $display("[TB] fill under backpressure");
    bus.i_issue_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(16'(k), 6'(k + 10), 32'h100 + 32'(k), 1'b1, 32'h200 + 32'(k), 1'b1);
      tick();
    end
    idle();
    checkOutput("fill_full", 32'(bus.o_full), 32'h1);
    checkOutput("fill_cnt", 32'(bus.o_cnt), 32'd8);
    checkOutput("fill_issue_vld", 32'(bus.o_issue_vld), 32'h1);
    checkOutput("fill_rrftag", 32'(bus.o_issue_rrftag), 32'd10);
    applyStimulus(16'hFFFF, 6'd63, 32'hBAD, 1'b1, 32'hBAD, 1'b1);
    tick();
    idle();
    checkOutput("drop_cnt", 32'(bus.o_cnt), 32'd8);
    checkOutput("hold_rrftag", 32'(bus.o_issue_rrftag), 32'd10);
    checkOutput("hold_src1", bus.o_issue_src1, 32'h100);
    bus.i_issue_rdy = 1'b1;
    tick();
    checkOutput("issue_cnt", 32'(bus.o_cnt), 32'd7);
    checkOutput("issue_not_full", 32'(bus.o_full), 32'h0);
    checkOutput("issue_next_rrftag", 32'(bus.o_issue_rrftag), 32'd11);
    applyStimulus(16'h0030, 6'd30, 32'h300, 1'b1, 32'h301, 1'b1);
    tick();
    idle();
    bus.i_issue_rdy = 1'b0;
    checkOutput("dp_issue_cnt", 32'(bus.o_cnt), 32'd7);
`ifdef RS_AGE_SEL_EN
    checkOutput("age_oldest_first", 32'(bus.o_issue_rrftag), 32'd12);
`else
    checkOutput("low_index_first", 32'(bus.o_issue_rrftag), 32'd30);
`endif

    $display("[TB] flush with concurrent dispatch");
    bus.i_flush = 1'b1;
    applyStimulus(16'h0040, 6'd40, 32'h400, 1'b1, 32'h401, 1'b1);
    tick();
    idle();
    checkOutput("flush_empty", 32'(bus.o_empty), 32'h1);
    checkOutput("flush_cnt", 32'(bus.o_cnt), 32'd0);
    checkOutput("flush_issue_vld", 32'(bus.o_issue_vld), 32'h0);
    tick();
    checkOutput("flush_dp_dropped", 32'(bus.o_empty), 32'h1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
